// File: rtl/pipe_stage_pkg.sv
// Shared constants for the skid-buffered pipeline stage register.
package pipe_stage_pkg;

  typedef logic [1:0] occ_t;

  localparam occ_t OCC_EMPTY = 2'd0;
  localparam occ_t OCC_ONE   = 2'd1;
  localparam occ_t OCC_FULL  = 2'd2;

  // NOP encoding placed on Q when a bubble is inserted; sliced to the payload width.
  localparam logic [63:0] NopValue = 64'h0;

endpackage

// File: rtl/pipe_slot_reg.sv
// One payload slot (data + valid) with load, clear-valid and hold controls.
module pipe_slot_reg #(
  parameter int unsigned       Width      = 32,
  parameter logic [Width-1:0]  ResetValue = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_clear,
  input  logic [Width-1:0] i_data,
  input  logic             i_valid,
  output logic [Width-1:0] o_data,
  output logic             o_valid
);

  logic [Width-1:0] r_data;
  logic             r_valid;

  // Load wins over clear; clear drops only the valid bit so data holds.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= ResetValue;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush, preset
// and a saturating stall counter. in_ready comes from registered state only.
module pipe_stage_skid_reg
  import pipe_stage_pkg::*;
#(
  parameter int unsigned          NrOfBits    = 32,
  parameter logic [NrOfBits-1:0]  ResetValue  = '0,
  parameter logic [NrOfBits-1:0]  PresetValue = '1,
  parameter logic [NrOfBits-1:0]  BubbleValue = NopValue[NrOfBits-1:0],
  parameter int unsigned          CntBits     = 16
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NrOfBits-1:0] D,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NrOfBits-1:0] Q,
  input  logic                cs,
  input  logic                pre,
  input  logic                flush,
  output logic [1:0]          occupancy,
  output logic [CntBits-1:0]  stall_cnt
);

  logic [NrOfBits-1:0] w_m_data, w_s_data;
  logic                w_m_valid, w_s_valid;
  logic                w_m_load, w_m_clear, w_m_valid_in;
  logic [NrOfBits-1:0] w_m_data_in;
  logic                w_s_load, w_s_clear;
  logic                w_acc, w_drn;
  logic [CntBits-1:0]  r_stall_cnt;

  assign w_acc = in_valid & ~w_s_valid;
  assign w_drn = w_m_valid & out_ready;

  always_comb begin
    w_m_load     = 1'b0;
    w_m_clear    = 1'b0;
    w_m_valid_in = 1'b0;
    w_m_data_in  = D;
    w_s_load     = 1'b0;
    w_s_clear    = 1'b0;
    if (pre) begin
      w_m_load     = 1'b1;
      w_m_valid_in = 1'b1;
      w_m_data_in  = PresetValue;
      w_s_clear    = 1'b1;
    end else if (flush) begin
      w_m_load     = 1'b1;
      w_m_data_in  = BubbleValue;
      w_s_clear    = 1'b1;
    end else if (Tick) begin
      if (!w_m_valid || w_drn) begin
        // Skid entry is always older than anything upstream, so it refills M first.
        if (w_s_valid) begin
          w_m_load     = 1'b1;
          w_m_valid_in = 1'b1;
          w_m_data_in  = w_s_data;
          w_s_clear    = 1'b1;
        end else if (w_acc) begin
          w_m_load     = 1'b1;
          w_m_valid_in = 1'b1;
        end else begin
          w_m_clear    = 1'b1;
        end
      end else if (w_acc) begin
        w_s_load = 1'b1;
      end
    end
  end

  pipe_slot_reg #(
    .Width      (NrOfBits),
    .ResetValue (ResetValue)
  ) u_main (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_load  (w_m_load),
    .i_clear (w_m_clear),
    .i_data  (w_m_data_in),
    .i_valid (w_m_valid_in),
    .o_data  (w_m_data),
    .o_valid (w_m_valid)
  );

  pipe_slot_reg #(
    .Width      (NrOfBits),
    .ResetValue (ResetValue)
  ) u_skid (
    .i_clk   (Clock),
    .i_rst   (Reset),
    .i_load  (w_s_load),
    .i_clear (w_s_clear),
    .i_data  (D),
    .i_valid (1'b1),
    .o_data  (w_s_data),
    .o_valid (w_s_valid)
  );

  // Preset leaves the counter alone; flush restarts it.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_stall_cnt <= '0;
    end else if (pre) begin
      r_stall_cnt <= r_stall_cnt;
    end else if (flush) begin
      r_stall_cnt <= '0;
    end else if (Tick && w_m_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_ready  = ~w_s_valid;
  assign out_valid = w_m_valid;
  assign Q         = cs ? {NrOfBits{1'bz}} : w_m_data;
  assign stall_cnt = r_stall_cnt;
  assign occupancy = (w_m_valid && w_s_valid) ? OCC_FULL :
                     (w_m_valid || w_s_valid) ? OCC_ONE  : OCC_EMPTY;

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Parametrised pipeline-stage register for the CPU datapath (EX/MEM-style immediates, ALU results, control words). It is the successor to the single-bit-configurable flip-flop stage register. It adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush that inserts a bubble, a configurable preset value and a saturating stall counter. Stages can then stall without combinational ready paths between them.

Parameters:
NrOfBits, 32, payload width (1..64)
ResetValue, 0, value of Q after Reset (NrOfBits wide)
PresetValue, all ones, value loaded into the main slot by pre
BubbleValue, 0, value of Q after flush (NOP encoding)
CntBits, 16, width of the stall counter

Ports:
Clock  in  1  system clock, rising edge only
Reset  in  1  synchronous, active-high reset
Tick  in  1  global advance enable; state frozen when 0 (except Reset)
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept; registered, equals !S_valid
D  in  NrOfBits  upstream payload
out_valid  out  1  main slot holds valid data
out_ready  in  1  downstream accepts
Q  out  NrOfBits  main-slot payload; high-Z when cs=1
cs  in  1  output disable (1 -> Q all 'z'; out_valid unaffected)
pre  in  1  synchronous preset
flush  in  1  synchronous bubble insert
occupancy  out  2  number of valid slots (0..2)
stall_cnt  out  CntBits  count of Tick cycles with out_valid & !out_ready

Behaviour:
- State: main slot M (data, valid) drives Q/out_valid; skid slot S (data, valid).
- Reset=1 at a clock edge: M_data=ResetValue, M_valid=0, S_valid=0, stall_cnt=0. Outputs after reset: out_valid=0, in_ready=1, occupancy=0, Q=ResetValue.
- Priority at each edge: Reset > pre > flush > Tick=0 hold > normal.
- pre=1: M_data=PresetValue, M_valid=1, S_valid=0. pre ignores Tick. Input offered that cycle is dropped.
- flush=1: M_data=BubbleValue, M_valid=0, S_valid=0, stall_cnt=0. flush ignores Tick. Input offered that cycle is dropped.
- Tick=0: no transfer occurs and nothing changes. Handshake signals still reflect state.
- Normal step, Tick=1, with acc = in_valid & in_ready and drn = M_valid & out_ready:
  - M empty or drn, S valid: M <= S, S_valid <= 0. acc is impossible here because in_ready=0.
  - M empty or drn, S empty: if acc, M <= D with M_valid=1; else M_valid <= 0 and M_data holds.
  - M valid and !drn: if acc, S <= D with S_valid=1; M holds.
- Latency: D to Q is 1 cycle when empty. Full throughput (1 beat/Tick) under continuous out_ready.
- No data loss or duplication: each accepted beat appears exactly once on Q, in order.
- in_ready depends only on registered state; there is no combinational path from out_ready.
- occupancy = M_valid + S_valid.
- stall_cnt increments on Tick cycles with out_valid & !out_ready and saturates at all ones.
- Tri-state Q exists for bus compatibility only. Top-level FPGA builds tie cs=0.

Decomposition:
- Package pipe_stage_pkg: occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2; default BubbleValue NOP constant.
- Sub-module pipe_slot_reg: one data+valid slot with load, clear and hold controls. Instantiate it twice, for M and S.

Test Plan:
- Reset, then stream D=1,2,3,4 with out_ready=1 and Tick=1 -> Q=1,2,3,4 on consecutive cycles, each 1 cycle after its accept; occupancy stays 1; stall_cnt=0.
- Accept D=0xA, hold out_ready=0, offer 0xB then 0xC -> 0xB accepted into S, in_ready=0 next cycle, 0xC held upstream, occupancy=2. Raise out_ready -> Q=0xA, 0xB, 0xC in order; stall_cnt equals the stalled Tick cycles.
- Occupancy=2, assert flush together with in_valid=1, D=0x55 -> next cycle out_valid=0, Q=BubbleValue, occupancy=0, 0x55 not captured, stall_cnt=0.
- Assert pre with NrOfBits=8 -> Q=0xFF, out_valid=1, S cleared. pre and Reset together -> Reset wins, Q=ResetValue.
- Tick=0 for 5 cycles with in_valid=1 and out_ready toggling -> no state change, no counter change. Tick=1 resumes exactly where it stopped.
- Force stall with CntBits=4 for 20 Tick cycles -> stall_cnt saturates at 15. cs=1 -> Q reads all 'z' while out_valid is unchanged.
